// File: rtl/conversor_bcd_serial_pkg.sv
// conversor_bcd_serial_pkg
// Shared definitions for the serial binary-to-BCD converter:
//   - default input width and digit count
//   - FSM state encoding (IDLE=0, SHIFT=1)
//   - counter width helper and its value for the default width
// Optional feature macro used by the top: BCD_BLANK_ZEROS_EN.
package conversor_bcd_serial_pkg;

  localparam int WIDTH_BIN_DEF = 26;
  localparam int N_DIGITS_DEF  = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Width of a down-counter that must hold the value w itself.
  function automatic int cntWidth(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CNT_W = cntWidth(WIDTH_BIN_DEF);

endpackage

// File: rtl/bcd_ajuste_digito.sv
// bcd_ajuste_digito
// Combinational add-3 correction cell of the shift-and-add-3 algorithm.
// A nibble of 5 or more gets 3 added so the following left shift carries
// correctly into the next decimal digit.
// Ports:
//   digit_i  4-bit BCD nibble before correction
//   digit_o  4-bit corrected nibble
module bcd_ajuste_digito (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;

endmodule

// File: rtl/conversor_bcd_serial.sv
// conversor_bcd_serial
// Iterative binary-to-BCD converter with a start/busy/done handshake.
// A conversion takes WIDTH_BIN shift cycles; the result register bcd_o only
// changes on the completing edge, so the displays never see a partial value.
// Ports:
//   clk_i     processor (divided) clock, rising edge
//   reset_i   synchronous active-high reset
//   start_i   conversion request, sampled only while idle
//   bin_i     unsigned binary value to convert
//   busy_o    conversion in progress
//   done_o    one-cycle pulse when bcd_o has been updated
//   bcd_o     packed BCD digits, [3:0] = units
//   blank_o   leading-zero blank mask per digit
// Optional feature: define BCD_BLANK_ZEROS_EN to generate the registered
// leading-zero mask; otherwise blank_o is tied to zero.
module conversor_bcd_serial
  import conversor_bcd_serial_pkg::*;
#(
  parameter int WIDTH_BIN = WIDTH_BIN_DEF,
  parameter int N_DIGITS  = N_DIGITS_DEF
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    start_i,
  input  logic [WIDTH_BIN-1:0]    bin_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [4*N_DIGITS-1:0]   bcd_o,
  output logic [N_DIGITS-1:0]     blank_o
);

  localparam int BcdW = 4 * N_DIGITS;
  localparam int RegW = BcdW + WIDTH_BIN;
  localparam int CntW = cntWidth(WIDTH_BIN);

  state_t              state_q, state_d;
  logic [RegW-1:0]     shiftReg_q, shiftReg_d;
  logic [CntW-1:0]     count_q, count_d;
  logic [BcdW-1:0]     bcd_q, bcd_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;

  logic [BcdW-1:0]     corrected;
  logic [RegW-1:0]     shifted;

  // One correction cell per BCD nibble of the working register.
  for (genvar g = 0; g < N_DIGITS; g++) begin : gAjuste
    bcd_ajuste_digito uAjuste (
      .digit_i (shiftReg_q[WIDTH_BIN + 4*g +: 4]),
      .digit_o (corrected[4*g +: 4])
    );
  end

  // Corrected BCD field above the untouched binary bits, then shift by one.
  assign shifted = {corrected, shiftReg_q[WIDTH_BIN-1:0]} << 1;

  // Next-state logic: load on start, shift while counting down, publish
  // the result on the cycle the counter runs out.
  always_comb begin
    state_d    = state_q;
    shiftReg_d = shiftReg_q;
    count_d    = count_q;
    bcd_d      = bcd_q;
    done_d     = 1'b0;
    busy_d     = busy_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          shiftReg_d = {{BcdW{1'b0}}, bin_i};
          count_d    = CntW'(WIDTH_BIN);
          busy_d     = 1'b1;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        shiftReg_d = shifted;
        count_d    = count_q - CntW'(1);
        if (count_q == CntW'(1)) begin
          bcd_d   = shifted[RegW-1 -: BcdW];
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial conversion.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      shiftReg_q <= '0;
      count_q    <= '0;
      bcd_q      <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shiftReg_q <= shiftReg_d;
      count_q    <= count_d;
      bcd_q      <= bcd_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign bcd_o  = bcd_q;

`ifdef BCD_BLANK_ZEROS_EN
  logic [N_DIGITS-1:0] blank_q, blank_d;

  // Digit i is blanked when it and every digit above it are zero; the
  // units digit is never blanked so a zero value still shows "0".
  always_comb begin
    logic allZero;
    blank_d = '0;
    allZero = 1'b1;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      allZero    = allZero & (bcd_d[4*i +: 4] == 4'd0);
      blank_d[i] = allZero;
    end
  end

  // Mask is updated on the same edge as the published digits.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      blank_q <= {{(N_DIGITS-1){1'b1}}, 1'b0};
    end else if (done_d) begin
      blank_q <= blank_d;
    end
  end

  assign blank_o = blank_q;
`else
  assign blank_o = '0;
`endif

endmodule

// File: tb/tb_conversor_bcd_serial.sv
// tb_conversor_bcd_serial
// Self-checking bench for conversor_bcd_serial. Expected digits come from
// decimal arithmetic on the input value; expected blank masks come from
// comparing the value against powers of ten.
module tb_conversor_bcd_serial;

  logic        clk;
  logic        reset;
  logic        start;
  logic [25:0] bin;
  logic        busy;
  logic        done;
  logic [31:0] bcd;
  logic [7:0]  blank;

  int nCompared;
  int nMismatched;

  conversor_bcd_serial dut (
    .clk_i   (clk),
    .reset_i (reset),
    .start_i (start),
    .bin_i   (bin),
    .busy_o  (busy),
    .done_o  (done),
    .bcd_o   (bcd),
    .blank_o (blank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decimal digits of v, units in the low nibble.
  function automatic logic [31:0] refBcd(input longint unsigned v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Digit i (i >= 1) is blank exactly when v < 10^i.
  function automatic logic [7:0] refBlank(input longint unsigned v);
    logic [7:0] m;
    longint unsigned p;
    m = '0;
`ifdef BCD_BLANK_ZEROS_EN
    p = 10;
    for (int i = 1; i < 8; i++) begin
      m[i] = (v < p);
      p = p * 10;
    end
`endif
    return m;
  endfunction

  function automatic logic [7:0] resetBlank();
`ifdef BCD_BLANK_ZEROS_EN
    return 8'hFE;
`else
    return 8'h00;
`endif
  endfunction

  // Drives one start pulse and follows the handshake until done or timeout.
  // Returns the period number of the done pulse (-1 on timeout) and the
  // number of periods with busy high.
  task automatic applyStimulus(input logic [25:0] v, output int lat, output int busyCnt);
    @(negedge clk);
    start = 1'b1;
    bin   = v;
    lat     = -1;
    busyCnt = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        bin   = 26'($urandom);
      end
      if (busy) busyCnt++;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b1;
    bin   = 26'd123;
    repeat (2) @(negedge clk);
    nCompared++;
    if (busy !== 1'b0 || done !== 1'b0 || bcd !== 32'h0 || blank !== resetBlank()) begin
      nMismatched++;
      $display("[TB] FAIL reset_state: busy=%b done=%b bcd=%h blank=%h, required 0 0 00000000 %h",
               busy, done, bcd, blank, resetBlank());
    end
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    nCompared++;
    if (busy !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL reset_beats_start: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_value(input string name, input logic [25:0] v, input logic checkBusy);
    int lat, busyCnt;
    applyStimulus(v, lat, busyCnt);
    nCompared++;
    if (lat !== 27) begin
      nMismatched++;
      $display("[TB] FAIL %s_latency: got %0d, required 27", name, lat);
    end
    nCompared++;
    if (bcd !== refBcd(longint'(v))) begin
      nMismatched++;
      $display("[TB] FAIL %s_bcd: got %h, required %h (bin=%0d)", name, bcd, refBcd(longint'(v)), v);
    end
    nCompared++;
    if (blank !== refBlank(longint'(v)) || busy !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL %s_blank_busy: blank=%h busy=%b, required %h 0", name, blank, busy, refBlank(longint'(v)));
    end
    if (checkBusy) begin
      nCompared++;
      if (busyCnt !== 26) begin
        nMismatched++;
        $display("[TB] FAIL %s_busy_cycles: got %0d, required 26", name, busyCnt);
      end
    end
    @(negedge clk);
    nCompared++;
    if (done !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL %s_done_pulse_width: done=%b one cycle later, required 0", name, done);
    end
  endtask

  task automatic test_known;
    test_value("zero", 26'd0, 1'b1);
    test_value("max", 26'd67108863, 1'b1);
    test_value("dec12345678", 26'd12345678, 1'b0);
    test_value("v305", 26'd305, 1'b0);
  endtask

  task automatic test_random;
    logic [25:0] v;
    for (int i = 0; i < 10; i++) begin
      if (i % 3 == 0) v = 26'($urandom_range(0, 999));
      else            v = 26'($urandom);
      test_value($sformatf("rand%0d", i), v, 1'b0);
    end
  endtask

  task automatic test_ignore_start;
    int firstDone, nDone;
    logic [31:0] captured;
    firstDone = -1;
    nDone     = 0;
    captured  = '0;
    @(negedge clk);
    start = 1'b1;
    bin   = 26'd99;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (done) begin
        nDone++;
        if (firstDone < 0) begin
          firstDone = k;
          captured  = bcd;
        end
      end
      if (k == 1) start = 1'b0;
      if (k == 4) begin
        start = 1'b1;
        bin   = 26'd42;
      end
      if (k == 5) start = 1'b0;
    end
    nCompared++;
    if (nDone !== 1 || firstDone !== 27) begin
      nMismatched++;
      $display("[TB] FAIL ignore_start_done: count=%0d first=%0d, required 1 at 27", nDone, firstDone);
    end
    nCompared++;
    if (captured !== 32'h00000099) begin
      nMismatched++;
      $display("[TB] FAIL ignore_start_bcd: got %h, required 00000099", captured);
    end
  endtask

  task automatic test_back_to_back;
    int doneCycles[$];
    @(negedge clk);
    start = 1'b1;
    bin   = 26'd7;
    for (int k = 1; k <= 81; k++) begin
      @(negedge clk);
      if (done) begin
        doneCycles.push_back(k);
        nCompared++;
        if (bcd !== 32'h00000007) begin
          nMismatched++;
          $display("[TB] FAIL held_bcd_cycle%0d: got %h, required 00000007", k, bcd);
        end
      end
    end
    start = 1'b0;
    nCompared++;
    if (doneCycles.size() != 3 || doneCycles[0] != 27 || doneCycles[1] != 54 || doneCycles[2] != 81) begin
      nMismatched++;
      $display("[TB] FAIL held_done_cycles: got %p, required '{27, 54, 81}", doneCycles);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic sawDone;
    sawDone = 1'b0;
    @(negedge clk);
    start = 1'b1;
    bin   = 26'd500;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    nCompared++;
    if (busy !== 1'b0 || done !== 1'b0 || bcd !== 32'h0 || blank !== resetBlank()) begin
      nMismatched++;
      $display("[TB] FAIL reset_mid: busy=%b done=%b bcd=%h blank=%h, required 0 0 00000000 %h",
               busy, done, bcd, blank, resetBlank());
    end
    reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done || bcd !== 32'h0) sawDone = 1'b1;
    end
    nCompared++;
    if (sawDone !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL reset_mid_no_done: late done or bcd change seen=%b, required 0", sawDone);
    end
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    reset = 1'b1;
    start = 1'b0;
    bin   = '0;
    test_reset();
    test_known();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
